vga_rect_fill: RTL and testbench
================================

# vga_rect_fill

Frame-buffer writer that sits directly upstream of the VGA scan-out stage. It accepts rectangle-fill commands over a valid/ready handshake and writes 12-bit RGB (4:4:4) pixels into the write port of the display RAM, one pixel per clock. The scan-out side reads the same RAM through its independent read port. Rectangles are clipped to the visible 640×480 area, and the frame-buffer address is `y*H_RES + x`.

## Interface

Parameters:
- `H_RES`, 640: visible pixels per line.
- `V_RES`, 480: visible lines per frame.
- `ADDR_W`, 19: frame-buffer address width; must satisfy `2^ADDR_W ≥ H_RES*V_RES`.
- `CLEAR_COLOUR`, 12'h000: colour written by the reset clear sweep (see Configuration).

Ports:
- `clk` input 1: pixel-domain clock; the same clock drives the display RAM write port.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_x0` input 10: left column.
- `cmd_y0` input 9: top line.
- `cmd_w` input 10: width in pixels.
- `cmd_h` input 9: height in lines.
- `cmd_colour` input 12: fill colour, {R[3:0],G[3:0],B[3:0]}.
- `fb_we` output 1: frame-buffer write enable.
- `fb_addr` output ADDR_W: write address.
- `fb_data` output 12: write data.
- `busy` output 1: fill or clear in progress.
- `done` output 1: one-cycle pulse when a command completes.

## Operation

- States are IDLE, FILL, and CLEAR (CLEAR exists only when the macro is defined).
- A command is accepted when `cmd_valid && cmd_ready`. `cmd_ready` is 1 only in IDLE.
- All command fields, including colour, are sampled at acceptance. Later changes on the input bus are ignored.
- Clipping:
  - `x_end = min(cmd_x0 + cmd_w, H_RES)`, computed at 11 bits.
  - `y_end = min(cmd_y0 + cmd_h, V_RES)`, computed at 10 bits.
  - A command is empty if `cmd_w==0`, `cmd_h==0`, `cmd_x0≥H_RES`, or `cmd_y0≥V_RES`.
- An empty command goes IDLE→IDLE. It produces no writes, and `done` pulses in the next cycle.
- A non-empty command goes IDLE→FILL. The block scans row-major from (x0,y0), with x ending at x_end-1 and y ending at y_end-1.
- Address generation is incremental and uses no multiplier:
  - `row_base` is loaded with `y0*H_RES` via the shift-add `(y0<<9)+(y0<<7)` when `H_RES==640`; otherwise a constant multiply is used.
  - `fb_addr = row_base + x`.
  - At row wrap, `row_base += H_RES` and x reloads to x0.
- On the last pixel write, FILL→IDLE.
- `busy` is 1 in FILL and CLEAR, and 0 in IDLE.
- Reset values: `fb_we=0`, `fb_addr=0`, `fb_data=0`, `done=0`, `busy=0`, `cmd_ready=1` (or `busy=1`, `cmd_ready=0` with the macro).
- Reset mid-operation abandons the fill immediately. No further writes occur, and no `done` is issued for the abandoned command.

## Timing

- Outputs `fb_we`, `fb_addr`, `fb_data`, `done`, and `busy` are registered. `cmd_ready` is decoded from state.
- The first write is presented in the cycle after acceptance.
- A fill of N = clipped_w × clipped_h pixels produces N consecutive cycles with `fb_we=1` and no bubbles, including across row wraps.
- `done` asserts in the cycle after the last write. In that same cycle `cmd_ready=1`, so back-to-back commands leave exactly one idle write cycle between them.
- `cmd_valid` held high while busy has no effect until `cmd_ready` rises.

## Configuration

- Macro: `VGA_RECT_FILL_CLEAR_ON_RESET_EN`.
- Defined:
  - After `rst_n` deasserts, the block enters CLEAR and writes `CLEAR_COLOUR` to addresses 0 … H_RES*V_RES-1, one per cycle.
  - During CLEAR, `busy=1` and `cmd_ready=0`, and no `done` is issued.
  - CLEAR→IDLE follows the last write, with `cmd_ready=1` in the next cycle.
- Undefined: no CLEAR state; the block resets directly into IDLE.

## Structure

- Shared package `vga_pkg` holds the constants `H_RES`, `V_RES`, and `ADDR_W`, plus typedef `rgb444_t` (12 bits).
- One sub-module, `fb_scan_ctr`, contains the x/row_base counter pair with load, step, and last-pixel flag. It is reused by the CLEAR sweep as a full-frame scan.

## Test plan

- Basic fill: cmd (10,20,w=3,h=2, colour 12'hF00) → 6 back-to-back writes to 12810, 12811, 12812, 13450, 13451, 13452 with data F00; `done` pulses one cycle after 13452.
- Corner clip: (638,479,w=5,h=4, 12'h0F0) → exactly 2 writes, to 307198 and 307199; then `done`.
- Empty command: w=0 (and separately x0=700) → no `fb_we`; `done` in the cycle after acceptance; `busy` stays 0.
- Back-to-back: `cmd_valid` held high with two commands queued → the second is accepted in the `done` cycle of the first, and its first write follows one cycle later; colour changes on the bus during FILL do not alter `fb_data`.
- Reset mid-fill: `rst_n` low during the 3rd write of a 4×4 fill → `fb_we` drops to 0 asynchronously and no `done` is issued; after release, `cmd_ready=1` (macro undefined).
- Clear sweep (macro defined): after reset → 307200 writes, addresses 0…307199, data `CLEAR_COLOUR`; `cmd_ready` rises the cycle after the last write.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : vga_pkg                                                      |
// | Description : Shared display geometry, pixel type and fill FSM states.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package vga_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLEAR = 2'd2
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_scan_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_scan_ctr                                                  |
// | Description : Row-major x/row_base scan counter with load, step and        |
// |               last-pixel flag; address is kept incrementally.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fb_scan_ctr
    import vga_pkg::*;
#(
    parameter int H_RES      = vga_pkg::H_RES,
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int RST_X_LAST = 0,
    parameter int RST_Y_LAST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [9:0]        x0_i,
    input  logic [8:0]        y0_i,
    input  logic [9:0]        x_last_i,
    input  logic [8:0]        y_last_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [9:0]        x_q, x_d, x0_q, x_last_q;
    logic [8:0]        y_q, y_d, y_last_q;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] w_load_base, w_next_base;
    logic              w_row_end;

    generate
        if (H_RES == 640) begin : g_shift_add
            assign w_load_base = (ADDR_W'(y0_i) << 9) + (ADDR_W'(y0_i) << 7);
        end else begin : g_const_mult
            assign w_load_base = ADDR_W'(y0_i) * ADDR_W'(H_RES);
        end
    endgenerate

    assign w_next_base = row_base_q + ADDR_W'(H_RES);
    assign w_row_end   = (x_q == x_last_q);
    assign last_o      = w_row_end && (y_q == y_last_q);
    assign addr_o      = addr_q;

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (load_i) begin
            x_d        = x0_i;
            y_d        = y0_i;
            row_base_d = w_load_base;
            addr_d     = w_load_base + ADDR_W'(x0_i);
        end else if (step_i) begin
            if (w_row_end) begin
                x_d        = x0_q;
                y_d        = y_q + 9'd1;
                row_base_d = w_next_base;
                addr_d     = w_next_base + ADDR_W'(x0_q);
            end else begin
                x_d    = x_q + 10'd1;
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // Reset bounds let the same counter run a full-frame sweep without a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            x_last_q   <= 10'(RST_X_LAST);
            y_last_q   <= 9'(RST_Y_LAST);
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            if (load_i) begin
                x0_q     <= x0_i;
                x_last_q <= x_last_i;
                y_last_q <= y_last_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_rect_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_rect_fill                                                |
// | Description : Clipped rectangle-fill writer for the VGA frame buffer.      |
// |               Optional reset clear sweep: VGA_RECT_FILL_CLEAR_ON_RESET_EN. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int      H_RES        = vga_pkg::H_RES,
    parameter int      V_RES        = vga_pkg::V_RES,
    parameter int      ADDR_W       = vga_pkg::ADDR_W,
    parameter rgb444_t CLEAR_COLOUR = 12'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [8:0]        cmd_y0,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [11:0]       cmd_colour,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              busy,
    output logic              done
);

`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
    localparam fill_state_t RST_STATE    = ST_CLEAR;
    localparam logic        RST_BUSY     = 1'b1;
    localparam int          SWEEP_X_LAST = H_RES - 1;
    localparam int          SWEEP_Y_LAST = V_RES - 1;
`else
    localparam fill_state_t RST_STATE    = ST_IDLE;
    localparam logic        RST_BUSY     = 1'b0;
    localparam int          SWEEP_X_LAST = 0;
    localparam int          SWEEP_Y_LAST = 0;
`endif

    fill_state_t       state_q;
    logic              fb_we_q;
    rgb444_t           fb_data_q;
    logic              busy_q;
    logic              done_q;

    logic [10:0]       w_x_sum, w_x_end;
    logic [9:0]        w_y_sum, w_y_end;
    logic [9:0]        w_x_last;
    logic [8:0]        w_y_last;
    logic              w_empty, w_accept, w_load, w_step, w_last;
    logic [ADDR_W-1:0] w_ctr_addr;

    assign w_x_sum  = {1'b0, cmd_x0} + {1'b0, cmd_w};
    assign w_y_sum  = {1'b0, cmd_y0} + {1'b0, cmd_h};
    assign w_x_end  = (w_x_sum > 11'(H_RES)) ? 11'(H_RES) : w_x_sum;
    assign w_y_end  = (w_y_sum > 10'(V_RES)) ? 10'(V_RES) : w_y_sum;
    assign w_x_last = 10'(w_x_end - 11'd1);
    assign w_y_last = 9'(w_y_end - 10'd1);
    assign w_empty  = (cmd_w == 10'd0) || (cmd_h == 9'd0) ||
                      ({1'b0, cmd_x0} >= 11'(H_RES)) || ({1'b0, cmd_y0} >= 10'(V_RES));

    assign cmd_ready = (state_q == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_load    = w_accept && !w_empty;
    // The sweep's first edge only raises fb_we; the counter already sits at address 0.
    assign w_step    = !w_last && ((state_q == ST_FILL) ||
                                   ((state_q == ST_CLEAR) && fb_we_q));

    fb_scan_ctr #(
        .H_RES      (H_RES),
        .ADDR_W     (ADDR_W),
        .RST_X_LAST (SWEEP_X_LAST),
        .RST_Y_LAST (SWEEP_Y_LAST)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_load),
        .step_i   (w_step),
        .x0_i     (cmd_x0),
        .y0_i     (cmd_y0),
        .x_last_i (w_x_last),
        .y_last_i (w_y_last),
        .addr_o   (w_ctr_addr),
        .last_o   (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            fb_we_q   <= 1'b0;
            fb_data_q <= '0;
            busy_q    <= RST_BUSY;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_empty) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= ST_FILL;
                            busy_q    <= 1'b1;
                            fb_we_q   <= 1'b1;
                            fb_data_q <= cmd_colour;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        fb_we_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!fb_we_q) begin
                        fb_we_q   <= 1'b1;
                        fb_data_q <= CLEAR_COLOUR;
                    end else if (w_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        fb_we_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    fb_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign fb_we   = fb_we_q;
    assign fb_addr = w_ctr_addr;
    assign fb_data = fb_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_rect_fill                                             |
// | Description : Self-checking bench for vga_rect_fill against a loop model.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_vga_rect_fill;

    localparam int H = 640;
    localparam int V = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0;
    logic [8:0]  cmd_y0 = '0;
    logic [9:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [11:0] cmd_colour = '0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_rect_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: enumerate the clipped rectangle row by row.
    task automatic model(input int x0, input int y0, input int w, input int h, output int q[$]);
        int xe = (x0 + w < H) ? x0 + w : H;
        int ye = (y0 + h < V) ? y0 + h : V;
        q.delete();
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                q.push_back(y * H + x);
    endtask

    task automatic scramble_bus();
        cmd_x0     = 10'($urandom);
        cmd_y0     = 9'($urandom);
        cmd_w      = 10'($urandom);
        cmd_h      = 9'($urandom);
        cmd_colour = 12'($urandom);
    endtask

    task automatic drive(input int x0, input int y0, input int w, input int h, input logic [11:0] col);
        cmd_x0     = 10'(x0);
        cmd_y0     = 9'(y0);
        cmd_w      = 10'(w);
        cmd_h      = 9'(h);
        cmd_colour = col;
    endtask

    // Entered at the negedge after acceptance; leaves at the negedge of the done cycle.
    task automatic check_writes(input string tag, input int q[$], input logic [11:0] col);
        foreach (q[i]) begin
            check({tag, "_wr"}, 64'({busy, done, fb_we, fb_addr, fb_data}),
                  64'({1'b1, 1'b0, 1'b1, 19'(q[i]), col}));
            @(negedge clk);
        end
        check({tag, "_done"}, 64'({busy, done, fb_we, cmd_ready}), 64'(4'b0101));
    endtask

    task automatic issue(input string tag, input int x0, input int y0, input int w, input int h,
                         input logic [11:0] col);
        int q[$];
        check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
        drive(x0, y0, w, h, col);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble_bus();
        model(x0, y0, w, h, q);
        check_writes(tag, q, col);
        @(negedge clk);
        check({tag, "_pulse"}, 64'({done, fb_we}), 64'(0));
    endtask

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int qa[$];
        int qb[$];
        logic exp_busy_rst;
        logic exp_ready_rst;
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
        exp_busy_rst  = 1'b1;
        exp_ready_rst = 1'b0;
`else
        exp_busy_rst  = 1'b0;
        exp_ready_rst = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("reset_state", 64'({fb_we, fb_addr, fb_data, done, busy, cmd_ready}),
              64'({1'b0, 19'd0, 12'd0, 1'b0, exp_busy_rst, exp_ready_rst}));
        rst_n = 1'b1;

`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
        begin
            int n = 0;
            int cyc = 0;
            @(negedge clk);
            while (cmd_ready !== 1'b1 && cyc < 310_000) begin
                if (fb_we === 1'b1) begin
                    check("clear_wr", 64'({fb_addr, fb_data, done}), 64'({19'(n), 12'h000, 1'b0}));
                    n++;
                end
                @(negedge clk);
                cyc++;
            end
            check("clear_count", 64'(n), 64'(H * V));
            check("clear_end", 64'({cmd_ready, busy, fb_we}), 64'(3'b100));
        end
`else
        @(negedge clk);
`endif

        issue("basic",   10,  20, 3, 2, 12'hF00);
        issue("corner", 638, 479, 5, 4, 12'h0F0);
        issue("empty_w",  50,  60, 0, 3, 12'h00F);
        issue("empty_x", 700,  10, 4, 4, 12'h555);
        issue("empty_y",  10, 500, 4, 4, 12'hAAA);
        issue("empty_h",  10,  10, 4, 0, 12'h123);

        // Back-to-back with cmd_valid held high and the next command on the bus.
        check("b2b_ready", 64'(cmd_ready), 64'(1));
        drive(200, 50, 5, 3, 12'h123);
        cmd_valid = 1'b1;
        @(negedge clk);
        drive(630, 470, 20, 20, 12'h456);
        model(200, 50, 5, 3, qa);
        check_writes("b2bA", qa, 12'h123);
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble_bus();
        model(630, 470, 20, 20, qb);
        check_writes("b2bB", qb, 12'h456);
        @(negedge clk);
        check("b2bB_pulse", 64'({done, fb_we}), 64'(0));

`ifndef VGA_RECT_FILL_CLEAR_ON_RESET_EN
        drive(100, 100, 4, 4, 12'hABC);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        model(100, 100, 4, 4, qa);
        for (int i = 0; i < 3; i++) begin
            check("rst_pre_wr", 64'({fb_we, fb_addr, fb_data}), 64'({1'b1, 19'(qa[i]), 12'hABC}));
            if (i < 2) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'({fb_we, busy, done, cmd_ready}), 64'(4'b0001));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_quiet", 64'({fb_we, done, busy, cmd_ready}), 64'(4'b0001));
        end
`endif

        for (int n = 0; n < 25; n++) begin
            int rx = (n % 3 == 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 639));
            int ry = (n % 4 == 0) ? int'($urandom_range(460, 500)) : int'($urandom_range(0, 479));
            int rw = int'($urandom_range(0, 40));
            int rh = int'($urandom_range(0, 12));
            issue("rand", rx, ry, rw, rh, 12'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
